// File: rtl/fp_cvt_l_d_seq_if.sv
// Operand/result handshake bundle for the FCVT.L.D sequencer.
// FCVT_UNSIGNED_EN adds the is_unsigned operand qualifier.
interface fp_cvt_l_d_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] d_in;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] l_out;
  logic        flag_nv;
  logic        flag_nx;
`ifdef FCVT_UNSIGNED_EN
  logic        is_unsigned;

  modport master (
    output in_valid, d_in, rm, out_ready, is_unsigned,
    input  in_ready, out_valid, l_out, flag_nv, flag_nx
  );
  modport slave (
    input  in_valid, d_in, rm, out_ready, is_unsigned,
    output in_ready, out_valid, l_out, flag_nv, flag_nx
  );
`else
  modport master (
    output in_valid, d_in, rm, out_ready,
    input  in_ready, out_valid, l_out, flag_nv, flag_nx
  );
  modport slave (
    input  in_valid, d_in, rm, out_ready,
    output in_ready, out_valid, l_out, flag_nv, flag_nx
  );
`endif
endinterface

// File: rtl/fp_cvt_l_d_seq.sv
// Iterative double -> signed 64-bit integer converter (FCVT.L.D) with RISC-V rounding.
// Define FCVT_UNSIGNED_EN to add FCVT.LU.D support via bus.is_unsigned.
module fp_cvt_l_d_seq #(
  parameter int unsigned SHIFT_STEP = 8
) (
  input logic              clk,
  input logic              rst,
  fp_cvt_l_d_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_e;

  localparam logic [6:0]  STEP    = 7'(SHIFT_STEP);
  localparam logic [63:0] S_MAX   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S_MIN   = 64'h8000_0000_0000_0000;
  localparam logic [64:0] TWO_P63 = 65'h0_8000_0000_0000_0000;

  state_e      state_q, state_d;
  logic [63:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic        left_q, left_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic [6:0]  rem_q, rem_d;
  logic [63:0] res_q, res_d;
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;

  logic               uns_in;
  logic               in_sgn;
  logic [10:0]        in_exp;
  logic [51:0]        in_frac;
  logic signed [12:0] in_e;
  logic [63:0]        pos_sat, neg_sat;
  logic [6:0]         k;
  logic [63:0]        below_k;
  logic [63:0]        pre_shift;
  logic               inc;
  logic [64:0]        sum;

`ifdef FCVT_UNSIGNED_EN
  assign uns_in = bus.is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.l_out     = res_q;
  assign bus.flag_nv   = nv_q;
  assign bus.flag_nx   = nx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      uns_q    <= 1'b0;
      rm_q     <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      left_q   <= left_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      nv_q     <= nv_d;
      nx_q     <= nx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    left_d   = left_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    rem_d    = rem_q;
    res_d    = res_q;
    nv_d     = nv_q;
    nx_d     = nx_q;

    in_sgn  = bus.d_in[63];
    in_exp  = bus.d_in[62:52];
    in_frac = bus.d_in[51:0];
    in_e    = $signed({2'b00, in_exp}) - 13'sd1023;
    pos_sat = uns_in ? '1 : S_MAX;
    neg_sat = uns_in ? '0 : S_MIN;

    k         = (rem_q < STEP) ? rem_q : STEP;
    below_k   = ((64'd1 << k) - 64'd1) >> 1;
    pre_shift = mag_q >> (k - 7'd1);

    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & (guard_q | sticky_q);
      3'd3:    inc = ~sign_q & (guard_q | sticky_q);
      3'd4:    inc = guard_q;
      default: inc = guard_q & (sticky_q | mag_q[0]);
    endcase
    sum = {1'b0, mag_q} + {64'd0, inc};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d   = in_sgn;
          rm_d     = bus.rm;
          uns_d    = uns_in;
          mag_d    = '0;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          rem_d    = '0;
          left_d   = 1'b0;
          if (in_exp == 11'h7FF) begin
            state_d = DONE;
            res_d   = (in_frac != '0 || !in_sgn) ? pos_sat : neg_sat;
            nv_d    = 1'b1;
            nx_d    = 1'b0;
          end else if (in_e >= 13'sd64 || (!uns_in && in_e == 13'sd63)) begin
            // -2^63 is the one representable value in the signed saturation band
            state_d = DONE;
            nx_d    = 1'b0;
            if (!uns_in && in_sgn && in_e == 13'sd63 && in_frac == '0) begin
              res_d = S_MIN;
              nv_d  = 1'b0;
            end else begin
              res_d = in_sgn ? neg_sat : pos_sat;
              nv_d  = 1'b1;
            end
          end else if (in_exp == '0) begin
            state_d  = ROUND;
            sticky_d = (in_frac != '0);
          end else if (in_e < 13'sd0) begin
            state_d  = ROUND;
            guard_d  = (in_e == -13'sd1);
            sticky_d = (in_e == -13'sd1) ? (in_frac != '0) : 1'b1;
          end else begin
            mag_d  = {11'd0, 1'b1, in_frac};
            left_d = (in_e > 13'sd52);
            rem_d  = (in_e > 13'sd52) ? 7'(in_e - 13'sd52) : 7'(13'sd52 - in_e);
            state_d = (in_e == 13'sd52) ? ROUND : ALIGN;
          end
        end
      end

      ALIGN: begin
        if (left_q) begin
          mag_d = mag_q << k;
        end else begin
          mag_d    = pre_shift >> 1;
          guard_d  = pre_shift[0];
          sticky_d = sticky_q | guard_q | (|(mag_q & below_k));
        end
        rem_d = rem_q - k;
        if (rem_d == '0) state_d = ROUND;
      end

      ROUND: begin
        state_d = DONE;
        nv_d    = 1'b0;
        nx_d    = guard_q | sticky_q;
        if (uns_q) begin
          if (!sign_q && sum[64]) begin
            res_d = '1;
            nv_d  = 1'b1;
            nx_d  = 1'b0;
          end else if (sign_q) begin
            res_d = '0;
            if (sum != '0) begin
              nv_d = 1'b1;
              nx_d = 1'b0;
            end
          end else begin
            res_d = sum[63:0];
          end
        end else if (!sign_q && sum >= TWO_P63) begin
          res_d = S_MAX;
          nv_d  = 1'b1;
          nx_d  = 1'b0;
        end else if (sign_q && sum > TWO_P63) begin
          res_d = S_MIN;
          nv_d  = 1'b1;
          nx_d  = 1'b0;
        end else begin
          res_d = sign_q ? (~sum[63:0] + 64'd1) : sum[63:0];
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_cvt_l_d_seq.sv
// Directed bench for fp_cvt_l_d_seq (SHIFT_STEP=8) with a queue of expected results.
module tb_fp_cvt_l_d_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct {
    logic [63:0] res;
    logic        nv;
    logic        nx;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_cvt_l_d_seq_if bus ();

  fp_cvt_l_d_seq #(.SHIFT_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one operand, wait for the result, compare against the queued expectation.
  task automatic conv(input string tag, input logic [63:0] d, input logic [2:0] r,
                      input logic [63:0] er, input logic env, input logic enx,
                      input int elat, input int stall);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    sb.push_back('{res: er, nv: env, nx: enx, lat: elat});
    bus.in_valid = 1'b1;
    bus.d_in     = d;
    bus.rm       = r;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    e = sb.pop_front();
    if (e.lat != 0) chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_l_out"}, bus.l_out, e.res);
    chk({tag, "_nv"}, 64'(bus.flag_nv), 64'(e.nv));
    chk({tag, "_nx"}, 64'(bus.flag_nx), 64'(e.nx));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_l_out"}, bus.l_out, e.res);
      chk({tag, "_hold_flags"}, {62'd0, bus.flag_nv, bus.flag_nx}, {62'd0, e.nv, e.nx});
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (stall != 0) begin
      chk({tag, "_release_in_ready"}, 64'(bus.in_ready), 64'd1);
      chk({tag, "_release_out_valid"}, 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int stale;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.d_in      = '0;
    bus.rm        = '0;
    bus.out_ready = 1'b0;
`ifdef FCVT_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_l_out", bus.l_out, 64'd0);
    chk("rst_flags", {62'd0, bus.flag_nv, bus.flag_nx}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    conv("one_rne",      64'h3FF0_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 9, 0);
    conv("m2p5_rne",     64'hC004_0000_0000_0000, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 0);
    conv("p2p5_rmm",     64'h4004_0000_0000_0000, 3'd4, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 9, 0);
    conv("p0p5_rup",     64'h3FE0_0000_0000_0000, 3'd3, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 2, 0);
    conv("m0p5_rdn",     64'hBFE0_0000_0000_0000, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2, 0);
    conv("p0p5_rne",     64'h3FE0_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2, 0);
    conv("m0p5_rne",     64'hBFE0_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2, 0);
    conv("p1p5_rne",     64'h3FF8_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 9, 0);
    conv("m1p5_rtz",     64'hBFF8_0000_0000_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 9, 0);
    conv("p3p75_rdn",    64'h400E_0000_0000_0000, 3'd2, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 9, 0);
    conv("p3p75_rup",    64'h400E_0000_0000_0000, 3'd3, 64'h0000_0000_0000_0004, 1'b0, 1'b1, 9, 0);
    conv("one_ulp_rup",  64'h3FF0_0000_0000_0001, 3'd3, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 9, 0);
    conv("one_ulp_rm7",  64'h3FF0_0000_0000_0001, 3'd7, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 9, 0);
    conv("m_one",        64'hBFF0_0000_0000_0000, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 9, 0);
    conv("p0p25_rne",    64'h3FD0_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2, 0);
    conv("p0p25_rup",    64'h3FD0_0000_0000_0000, 3'd3, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 2, 0);
    conv("zero",         64'h0000_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 2, 0);
    conv("neg_zero",     64'h8000_0000_0000_0000, 3'd2, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 2, 0);
    conv("subn_rup",     64'h0000_0000_0000_0001, 3'd3, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 2, 0);
    conv("subn_rne",     64'h0000_0000_0000_0001, 3'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2, 0);
    conv("two_p63",      64'h43E0_0000_0000_0000, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    conv("m_two_p63",    64'hC3E0_0000_0000_0000, 3'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1, 0);
    conv("m_big",        64'hC3E0_0000_0000_0001, 3'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1, 0);
    conv("nan",          64'h7FF8_0000_0000_0000, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    conv("neg_nan",      64'hFFF8_0000_0000_0001, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    conv("p_inf",        64'h7FF0_0000_0000_0000, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    conv("m_inf",        64'hFFF0_0000_0000_0000, 3'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1, 0);
    conv("left_53",      64'h4340_0000_0000_0001, 3'd1, 64'h0020_0000_0000_0002, 1'b0, 1'b0, 3, 0);
    conv("two_p62",      64'h43D0_0000_0000_0000, 3'd0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 4, 0);
    conv("max_below63",  64'h43DF_FFFF_FFFF_FFFF, 3'd3, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0, 4, 0);
    conv("stall_m2p5",   64'hC004_0000_0000_0000, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 5);

    // Reset while the aligner is busy: result must be abandoned.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.d_in     = 64'h3FF0_0000_0000_0000;
    bus.rm       = 3'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_l_out", bus.l_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    chk("mid_rst_no_stale", 64'(stale), 64'd0);
    conv("after_rst",    64'h4004_0000_0000_0000, 3'd0, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 9, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
